reorder_buffer: RTL and testbench

//  Circular in-order commit queue of ROB_DEPTH = 2**ROB_WIDTH_BIT entries. It is the ROB side of the register-file interface.

---
 rtl/reorder_buffer.sv | 156 +++++++++++++++
 tb/tb_reorder_buffer.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reorder_buffer.sv
// In-order commit queue: allocates on issue, fills on CDB writeback, retires the head and flushes on mispredict.
// Earliest commit is the edge after writeback; issue_ready drops while full, rdy_in low freezes all state.
module reorder_buffer #(
  parameter int ROB_WIDTH_BIT = 3
) (
  input  logic                     clk_in,
  input  logic                     rst_n_in,
  input  logic                     rdy_in,
  input  logic                     issue_valid,
  input  logic [1:0]               issue_type,
  input  logic [4:0]               issue_rd,
  input  logic                     issue_pred_taken,
  input  logic [31:0]              issue_pc,
  output logic                     issue_ready,
  output logic [ROB_WIDTH_BIT-1:0] issue_rob_id,
  input  logic                     wb_valid,
  input  logic [ROB_WIDTH_BIT-1:0] wb_rob_id,
  input  logic [31:0]              wb_value,
  input  logic                     wb_taken,
  input  logic [31:0]              wb_target,
  output logic [4:0]               set_dep_reg_id,
  output logic [ROB_WIDTH_BIT-1:0] set_dep_rob_id,
  output logic [4:0]               set_reg_id,
  output logic [31:0]              set_val,
  output logic [ROB_WIDTH_BIT-1:0] set_reg_on_rob_id,
  output logic                     store_commit,
  input  logic [ROB_WIDTH_BIT-1:0] get_rob_id1,
  input  logic [ROB_WIDTH_BIT-1:0] get_rob_id2,
  output logic                     rob_value1_ready,
  output logic [31:0]              rob_value1,
  output logic                     rob_value2_ready,
  output logic [31:0]              rob_value2,
  output logic                     rob_clear,
  output logic [31:0]              clear_pc
);

  localparam int W     = ROB_WIDTH_BIT;
  localparam int DEPTH = 1 << W;
  localparam logic [W:0] FULL = (W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    T_REG = 2'd0,
    T_BR  = 2'd1,
    T_ST  = 2'd2,
    T_RSV = 2'd3
  } rob_type_e;

  typedef struct packed {
    logic        busy;
    logic        ready;
    rob_type_e   kind;
    logic [4:0]  rd;
    logic        pred;
    logic [31:0] pc;
    logic [31:0] value;
    logic        taken;
    logic [31:0] target;
  } rob_entry_t;

  rob_entry_t ent [DEPTH];
  logic [W-1:0] head;
  logic [W-1:0] tail;
  logic [W:0]   count;

  rob_entry_t hd;
  logic       commit_go;
  logic       reg_commit;
  logic       issue_acc;

  assign hd = ent[head];

  // Retirement looks only at registered state, so a same-cycle writeback to the head waits one edge.
  assign commit_go  = rdy_in && (count != '0) && hd.busy && hd.ready;
  assign reg_commit = commit_go && (hd.kind == T_REG);

  assign rob_clear    = commit_go && (hd.kind == T_BR) && (hd.taken != hd.pred);
  assign clear_pc     = rob_clear ? (hd.taken ? hd.target : hd.pc + 32'd4) : 32'd0;
  assign store_commit = commit_go && (hd.kind == T_ST);

  assign set_reg_id        = reg_commit ? hd.rd : 5'd0;
  assign set_val           = reg_commit ? hd.value : 32'd0;
  assign set_reg_on_rob_id = reg_commit ? head : '0;

  assign issue_ready  = (count != FULL);
  assign issue_rob_id = tail;
  assign issue_acc    = rst_n_in && rdy_in && issue_valid && issue_ready && !rob_clear;

  assign set_dep_reg_id = (issue_acc && (issue_type == T_REG)) ? issue_rd : 5'd0;
  assign set_dep_rob_id = (rst_n_in && rdy_in) ? tail : '0;

  function automatic logic [32:0] lookup(input logic [W-1:0] id, input rob_entry_t e);
    logic [32:0] r;
    r = '0;
    if (!rst_n_in)
      r = '0;
    else if (wb_valid && (wb_rob_id == id))
      r = {1'b1, wb_value};
    else if (e.busy && e.ready)
      r = {1'b1, e.value};
    return r;
  endfunction

  always_comb begin
    {rob_value1_ready, rob_value1} = lookup(get_rob_id1, ent[get_rob_id1]);
    {rob_value2_ready, rob_value2} = lookup(get_rob_id2, ent[get_rob_id2]);
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
    end else if (rdy_in) begin
      if (rob_clear) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
        for (int i = 0; i < DEPTH; i++) begin
          ent[i].busy  <= 1'b0;
          ent[i].ready <= 1'b0;
        end
      end else begin
        if (wb_valid && ent[wb_rob_id].busy) begin
          ent[wb_rob_id].ready  <= 1'b1;
          ent[wb_rob_id].value  <= wb_value;
          ent[wb_rob_id].taken  <= wb_taken;
          ent[wb_rob_id].target <= wb_target;
        end
        if (issue_acc) begin
          ent[tail].busy   <= 1'b1;
          ent[tail].ready  <= 1'b0;
          ent[tail].kind   <= rob_type_e'(issue_type);
          ent[tail].rd     <= issue_rd;
          ent[tail].pred   <= issue_pred_taken;
          ent[tail].pc     <= issue_pc;
          ent[tail].value  <= 32'd0;
          ent[tail].taken  <= 1'b0;
          ent[tail].target <= 32'd0;
          tail             <= tail + W'(1);
        end
        if (commit_go) begin
          ent[head].busy  <= 1'b0;
          ent[head].ready <= 1'b0;
          head            <= head + W'(1);
        end
        case ({issue_acc, commit_go})
          2'b10:   count <= count + (W + 1)'(1);
          2'b01:   count <= count - (W + 1)'(1);
          default: count <= count;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: retirements are checked against a scoreboard of expected commits.
module tb_reorder_buffer;

  logic        clk_in, rst_n_in, rdy_in;
  logic        issue_valid, issue_pred_taken;
  logic [1:0]  issue_type;
  logic [4:0]  issue_rd;
  logic [31:0] issue_pc;
  logic        issue_ready;
  logic [2:0]  issue_rob_id;
  logic        wb_valid, wb_taken;
  logic [2:0]  wb_rob_id;
  logic [31:0] wb_value, wb_target;
  logic [4:0]  set_dep_reg_id, set_reg_id;
  logic [2:0]  set_dep_rob_id, set_reg_on_rob_id;
  logic [31:0] set_val;
  logic        store_commit;
  logic [2:0]  get_rob_id1, get_rob_id2;
  logic        rob_value1_ready, rob_value2_ready;
  logic [31:0] rob_value1, rob_value2;
  logic        rob_clear;
  logic [31:0] clear_pc;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int          kind;
    logic [31:0] a;
    logic [31:0] v;
    logic [31:0] id;
  } exp_t;
  exp_t sb[$];

  reorder_buffer #(.ROB_WIDTH_BIT(3)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in),
    .issue_valid(issue_valid), .issue_type(issue_type), .issue_rd(issue_rd),
    .issue_pred_taken(issue_pred_taken), .issue_pc(issue_pc),
    .issue_ready(issue_ready), .issue_rob_id(issue_rob_id),
    .wb_valid(wb_valid), .wb_rob_id(wb_rob_id), .wb_value(wb_value),
    .wb_taken(wb_taken), .wb_target(wb_target),
    .set_dep_reg_id(set_dep_reg_id), .set_dep_rob_id(set_dep_rob_id),
    .set_reg_id(set_reg_id), .set_val(set_val), .set_reg_on_rob_id(set_reg_on_rob_id),
    .store_commit(store_commit),
    .get_rob_id1(get_rob_id1), .get_rob_id2(get_rob_id2),
    .rob_value1_ready(rob_value1_ready), .rob_value1(rob_value1),
    .rob_value2_ready(rob_value2_ready), .rob_value2(rob_value2),
    .rob_clear(rob_clear), .clear_pc(clear_pc)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic issue(input logic [1:0] t, input logic [4:0] rd, input logic pr, input logic [31:0] pc);
    issue_valid = 1'b1; issue_type = t; issue_rd = rd; issue_pred_taken = pr; issue_pc = pc;
  endtask

  task automatic wb(input logic [2:0] id, input logic [31:0] v, input logic tk, input logic [31:0] tg);
    wb_valid = 1'b1; wb_rob_id = id; wb_value = v; wb_taken = tk; wb_target = tg;
  endtask

  task automatic idle();
    issue_valid = 1'b0;
    wb_valid    = 1'b0;
  endtask

  // Every visible retirement must match the oldest pending expectation.
  always @(negedge clk_in) begin : monitor
    exp_t e;
    if (rst_n_in && (set_reg_id != 5'd0 || store_commit || rob_clear)) begin
      chk("sb_pending", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        case (e.kind)
          0: begin
            chk("commit_rd", 32'(set_reg_id), e.a);
            chk("commit_val", set_val, e.v);
            chk("commit_id", 32'(set_reg_on_rob_id), e.id);
            chk("commit_no_clear", 32'(rob_clear), 32'd0);
          end
          1: begin
            chk("clear_flag", 32'(rob_clear), 32'd1);
            chk("clear_pc", clear_pc, e.a);
          end
          default: chk("store_commit", 32'(store_commit), 32'd1);
        endcase
      end
    end
  end

  initial begin
    rst_n_in = 1'b0; rdy_in = 1'b1;
    issue_valid = 1'b0; issue_type = 2'd0; issue_rd = 5'd0; issue_pred_taken = 1'b0; issue_pc = 32'd0;
    wb_valid = 1'b0; wb_rob_id = 3'd0; wb_value = 32'd0; wb_taken = 1'b0; wb_target = 32'd0;
    get_rob_id1 = 3'd0; get_rob_id2 = 3'd0;

    // Reset: outputs held at reset values even with live inputs.
    #12;
    issue(2'd0, 5'd4, 1'b0, 32'h0);
    wb(3'd0, 32'h1234, 1'b0, 32'h0);
    #1;
    chk("rst_issue_ready", 32'(issue_ready), 32'd1);
    chk("rst_issue_rob_id", 32'(issue_rob_id), 32'd0);
    chk("rst_dep_reg", 32'(set_dep_reg_id), 32'd0);
    chk("rst_lookup_rdy", 32'(rob_value1_ready), 32'd0);
    chk("rst_lookup_val", rob_value1, 32'd0);
    chk("rst_clear", 32'(rob_clear), 32'd0);
    idle();
    rst_n_in = 1'b1;
    tick();

    // Three register writes.
    for (int i = 0; i < 3; i++) begin
      issue(2'd0, 5'(i + 1), 1'b0, 32'(4 * i));
      #1;
      chk("iss_rob_id", 32'(issue_rob_id), 32'(i));
      chk("iss_dep_reg", 32'(set_dep_reg_id), 32'(i + 1));
      chk("iss_dep_rob", 32'(set_dep_rob_id), 32'(i));
      tick();
    end
    idle();

    wb(3'd2, 32'h33, 1'b0, 32'h0);
    #1;
    chk("no_early_commit", 32'(set_reg_id), 32'd0);
    tick();
    wb(3'd0, 32'h11, 1'b0, 32'h0);
    sb.push_back('{0, 32'd1, 32'h11, 32'd0});
    tick();
    idle();
    tick();
    #1;
    chk("head_blocked", 32'(set_reg_id), 32'd0);

    // Fill remaining six slots; tail wraps 7 -> 0 -> 1.
    for (int i = 0; i < 6; i++) begin
      issue(2'd0, 5'(10 + i), 1'b0, 32'h100);
      #1;
      chk("fill_rob_id", 32'(issue_rob_id), 32'((3 + i) % 8));
      tick();
    end
    issue(2'd0, 5'd20, 1'b0, 32'h0);
    #1;
    chk("full_not_ready", 32'(issue_ready), 32'd0);
    chk("full_no_dep", 32'(set_dep_reg_id), 32'd0);
    tick();
    idle();
    #1;
    chk("full_tail_held", 32'(issue_rob_id), 32'd1);
    wb(3'd1, 32'h22, 1'b0, 32'h0);
    sb.push_back('{0, 32'd2, 32'h22, 32'd1});
    sb.push_back('{0, 32'd3, 32'h33, 32'd2});
    tick();
    idle();
    #1;
    chk("full_while_commit", 32'(issue_ready), 32'd0);
    tick();
    #1;
    chk("ready_after_commit", 32'(issue_ready), 32'd1);
    chk("tail_after_commit", 32'(issue_rob_id), 32'd1);
    tick();

    // Lookup: writeback forwarding, then stored value.
    wb(3'd5, 32'hABCD, 1'b0, 32'h0);
    get_rob_id1 = 3'd5; get_rob_id2 = 3'd2;
    #1;
    chk("lk_fwd_rdy", 32'(rob_value1_ready), 32'd1);
    chk("lk_fwd_val", rob_value1, 32'hABCD);
    chk("lk_free_rdy", 32'(rob_value2_ready), 32'd0);
    tick();
    idle();
    get_rob_id2 = 3'd4;
    #1;
    chk("lk_stored_rdy", 32'(rob_value1_ready), 32'd1);
    chk("lk_stored_val", rob_value1, 32'hABCD);
    chk("lk_unready", 32'(rob_value2_ready), 32'd0);
    get_rob_id1 = 3'd6; get_rob_id2 = 3'd6;

    // Drain ids 3..7,0 back to back.
    wb(3'd3, 32'h303, 1'b0, 32'h0); sb.push_back('{0, 32'd10, 32'h303, 32'd3}); tick();
    wb(3'd4, 32'h304, 1'b0, 32'h0); sb.push_back('{0, 32'd11, 32'h304, 32'd4});
    sb.push_back('{0, 32'd12, 32'hABCD, 32'd5}); tick();
    wb(3'd6, 32'h306, 1'b0, 32'h0); sb.push_back('{0, 32'd13, 32'h306, 32'd6}); tick();
    wb(3'd7, 32'h307, 1'b0, 32'h0); sb.push_back('{0, 32'd14, 32'h307, 32'd7}); tick();
    wb(3'd0, 32'h300, 1'b0, 32'h0); sb.push_back('{0, 32'd15, 32'h300, 32'd0}); tick();
    wb(3'd2, 32'h77, 1'b0, 32'h0);
    tick();
    idle();
    get_rob_id2 = 3'd2;
    #1;
    chk("wb_nonbusy_ignored", 32'(rob_value2_ready), 32'd0);
    tick();
    #1;
    chk("drained_ready", 32'(issue_ready), 32'd1);
    chk("drained_sb", 32'(sb.size()), 32'd0);

    // Mispredicted taken branch at the head.
    issue(2'd1, 5'd0, 1'b0, 32'h40);
    #1;
    chk("br_rob_id", 32'(issue_rob_id), 32'd1);
    chk("br_no_dep", 32'(set_dep_reg_id), 32'd0);
    tick();
    issue(2'd0, 5'd5, 1'b0, 32'h44);
    tick();
    idle();
    wb(3'd1, 32'h0, 1'b1, 32'h100);
    sb.push_back('{1, 32'h100, 32'h0, 32'd0});
    tick();
    wb(3'd2, 32'h55, 1'b0, 32'h0);
    issue(2'd0, 5'd7, 1'b0, 32'h48);
    #1;
    chk("br_clear", 32'(rob_clear), 32'd1);
    chk("br_clear_pc", clear_pc, 32'h100);
    chk("clear_drops_issue", 32'(set_dep_reg_id), 32'd0);
    tick();
    idle();
    #1;
    chk("post_clear_id", 32'(issue_rob_id), 32'd0);
    chk("post_clear_ready", 32'(issue_ready), 32'd1);
    chk("post_clear_lookup", 32'(rob_value2_ready), 32'd0);
    tick();

    // Store, then not-taken branch predicted taken.
    issue(2'd2, 5'd0, 1'b0, 32'h80);
    #1;
    chk("st_rob_id", 32'(issue_rob_id), 32'd0);
    tick();
    issue(2'd1, 5'd0, 1'b1, 32'h200);
    tick();
    idle();
    wb(3'd0, 32'h0, 1'b0, 32'h0);
    sb.push_back('{2, 32'h0, 32'h0, 32'd0});
    tick();
    wb(3'd1, 32'h0, 1'b0, 32'h999);
    sb.push_back('{1, 32'h204, 32'h0, 32'd0});
    tick();
    idle();
    tick();

    // rdy_in low freezes the pending commit and blocks issue.
    issue(2'd0, 5'd9, 1'b0, 32'h300);
    tick();
    idle();
    wb(3'd0, 32'h99, 1'b0, 32'h0);
    tick();
    idle();
    rdy_in = 1'b0;
    issue(2'd0, 5'd4, 1'b0, 32'h304);
    #1;
    chk("pause_no_commit", 32'(set_reg_id), 32'd0);
    chk("pause_no_dep", 32'(set_dep_reg_id), 32'd0);
    tick();
    rdy_in = 1'b1;
    idle();
    sb.push_back('{0, 32'd9, 32'h99, 32'd0});
    #1;
    chk("pause_tail_held", 32'(issue_rob_id), 32'd1);
    tick();

    // Asynchronous reset between edges, mid-burst.
    issue(2'd0, 5'd6, 1'b0, 32'h400);
    tick();
    issue(2'd0, 5'd7, 1'b0, 32'h404);
    wb(3'd1, 32'h1, 1'b0, 32'h0);
    get_rob_id1 = 3'd1;
    #1;
    chk("pre_rst_lookup", 32'(rob_value1_ready), 32'd1);
    #1;
    rst_n_in = 1'b0;
    #1;
    chk("arst_issue_ready", 32'(issue_ready), 32'd1);
    chk("arst_rob_id", 32'(issue_rob_id), 32'd0);
    chk("arst_dep_reg", 32'(set_dep_reg_id), 32'd0);
    chk("arst_lookup_rdy", 32'(rob_value1_ready), 32'd0);
    chk("arst_lookup_val", rob_value1, 32'd0);
    chk("final_sb_empty", 32'(sb.size()), 32'd0);
    idle();
    tick();
    rst_n_in = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
